// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B4 pipelined master for line bursts and single words.
// Line bursts start at the critical word and wrap within the line. Beats are
// issued back-to-back without waiting for acknowledges. The master retries a
// bounded number of times on rty_i and reports an error on err_i, when the
// retries run out, or when no ack arrives for too long.
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i / req_ready_o       request handshake (ready only when idle)
//   req_addr_i, req_we_i,           byte address, write flag,
//   req_line_i                      line burst (1) or single word (0)
//   req_sel_i, req_wdata_i          byte enables and write data across the line
//   rsp_valid_o, rsp_err_o          one-cycle completion pulse and error flag
//   rsp_data_o                      read buffer, stable until the next request
//   cyc_o, stb_o, we_o, adr_o,      Wishbone master outputs
//   dat_o, sel_o, cti_o, bte_o
//   dat_i, ack_i, err_i, rty_i,     Wishbone slave responses
//   stall_i
module wb_burst_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LINE_W    = 128,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                req_we_i,
  input  logic                req_line_i,
  input  logic [LINE_W/8-1:0] req_sel_i,
  input  logic [LINE_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  output logic                rsp_err_o,
  output logic [LINE_W-1:0]   rsp_data_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  output logic [DATA_W/8-1:0] sel_o,
  output logic [2:0]          cti_o,
  output logic [1:0]          bte_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic                rty_i,
  input  logic                stall_i
);

  localparam int BEATS  = LINE_W / DATA_W;
  localparam int SEL_W  = DATA_W / 8;
  localparam int LSEL_W = LINE_W / 8;
  localparam int OFF_LO = $clog2(SEL_W);
  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_BACKOFF = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] BTE_LINE = (BEATS == 16) ? 2'b11 :
                                    (BEATS == 8)  ? 2'b10 :
                                    (BEATS == 4)  ? 2'b01 : 2'b00;
  localparam logic [CNT_W-1:0] N_LINE  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_MSK = IDX_W'(BEATS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic              line_reg;
  logic [LSEL_W-1:0] sel_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  iss_cnt_reg;
  logic [CNT_W-1:0]  ack_cnt_reg;
  logic [RTY_W-1:0]  retry_cnt_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;

  logic              busy;
  logic              accept;
  logic              ack_ok;
  logic              buf_wr;
  logic [CNT_W-1:0]  n_beats;
  logic [CNT_W-1:0]  iss_next;
  logic [CNT_W-1:0]  ack_next;
  logic [TMO_W-1:0]  tmo_next;
  logic [IDX_W-1:0]  w0;
  logic [IDX_W-1:0]  issue_idx;
  logic [IDX_W-1:0]  ack_idx;
  logic [ADDR_W-1:0] line_adr;

  assign busy    = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
  assign accept  = stb_o && !stall_i;
  assign n_beats = line_reg ? N_LINE : CNT_W'(1);

  // A beat accepted in the same cycle counts as outstanding, so a zero-latency
  // ack of that beat is taken rather than dropped as spurious.
  assign iss_next = iss_cnt_reg + CNT_W'(accept);
  assign ack_ok   = busy && ack_i && (ack_cnt_reg < iss_next);
  assign ack_next = ack_cnt_reg + CNT_W'(ack_ok);
  assign tmo_next = ack_i ? '0 :
                    (tmo_cnt_reg == TMO_MAX) ? tmo_cnt_reg : tmo_cnt_reg + 1'b1;

  // Critical word and the wrapped word index of the beat on the bus / being acked.
  assign w0        = IDX_W'((addr_reg >> OFF_LO) & ADDR_W'(BEATS - 1));
  assign issue_idx = (w0 + IDX_W'(iss_cnt_reg)) & IDX_MSK;
  assign ack_idx   = (w0 + IDX_W'(ack_cnt_reg)) & IDX_MSK;
  assign line_adr  = (addr_reg & ~ADDR_W'(LSEL_W - 1)) | (ADDR_W'(issue_idx) << OFF_LO);

  // Bus outputs decode registered state only; idle fields read as zero.
  assign req_ready_o = (state_reg == S_IDLE);
  assign cyc_o       = busy;
  assign stb_o       = (state_reg == S_ISSUE);
  assign we_o        = busy && we_reg;
  assign adr_o       = !stb_o ? '0 : (line_reg ? line_adr : addr_reg);
  assign dat_o       = !stb_o ? '0 : wdata_reg[int'(issue_idx)*DATA_W +: DATA_W];
  assign sel_o       = !stb_o ? '0 : (line_reg ? '1 : sel_reg[int'(w0)*SEL_W +: SEL_W]);
  assign cti_o       = !(stb_o && line_reg) ? 3'b000 :
                       (iss_cnt_reg == N_LAST) ? 3'b111 : 3'b010;
  assign bte_o       = (stb_o && line_reg) ? BTE_LINE : 2'b00;
  assign rsp_valid_o = (state_reg == S_RESP);
  assign rsp_err_o   = rsp_valid_o && err_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      line_reg      <= 1'b0;
      sel_reg       <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      iss_cnt_reg   <= '0;
      ack_cnt_reg   <= '0;
      retry_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_reg      <= req_addr_i;
            we_reg        <= req_we_i;
            line_reg      <= req_line_i;
            sel_reg       <= req_sel_i;
            wdata_reg     <= req_wdata_i;
            err_reg       <= 1'b0;
            iss_cnt_reg   <= '0;
            ack_cnt_reg   <= '0;
            retry_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            state_reg     <= S_ISSUE;
          end
        end
        S_ISSUE, S_DRAIN: begin
          iss_cnt_reg <= iss_next;
          ack_cnt_reg <= ack_next;
          tmo_cnt_reg <= tmo_next;
          if (err_i) begin
            err_reg   <= 1'b1;
            state_reg <= S_RESP;
          end else if (rty_i) begin
            if (retry_cnt_reg < RTY_MAX) begin
              state_reg <= S_BACKOFF;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= S_RESP;
            end
          end else if (!ack_i && (tmo_next == TMO_MAX)) begin
            err_reg   <= 1'b1;
            state_reg <= S_RESP;
          end else if (ack_next == n_beats) begin
            // ack_next never exceeds iss_next, so every beat has been issued.
            state_reg <= S_RESP;
          end else if (iss_next == n_beats) begin
            state_reg <= S_DRAIN;
          end
        end
        S_BACKOFF: begin
          retry_cnt_reg <= retry_cnt_reg + 1'b1;
          iss_cnt_reg   <= '0;
          ack_cnt_reg   <= '0;
          tmo_cnt_reg   <= '0;
          state_reg     <= S_ISSUE;
        end
        S_RESP:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Read buffer: one register per line word. Single reads fill every word.
  assign buf_wr = ack_ok && !err_i && !rty_i && !we_reg;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          word_reg <= '0;
        end else if (buf_wr && (!line_reg || (ack_idx == IDX_W'(gi)))) begin
          word_reg <= dat_i;
        end
      end
      assign rsp_data_o[gi*DATA_W +: DATA_W] = word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: randomized bench for wb_burst_master (4-word lines,
// MAX_RETRY=3, TIMEOUT=8). A behavioural Wishbone slave answers the bus; a
// request-level model predicts beats, responses, read buffer and memory.
module tb_wb_burst_master;

  localparam int NB      = 4;
  localparam int MAXR    = 3;
  localparam int TMO     = 8;

  typedef struct packed {
    logic [31:0]  addr;
    logic         we;
    logic         line;
    logic [15:0]  sel;
    logic [127:0] wdata;
    int           lat;
    int           stall_pct;
    int           stall_beat;
    int           rty_n;
    int           err_beat;
    logic         noack;
  } txn_t;

  typedef struct packed {
    int          k;
    int          cyc;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } pend_t;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [31:0]  req_addr_i = '0;
  logic         req_we_i = 1'b0;
  logic         req_line_i = 1'b0;
  logic [15:0]  req_sel_i = '0;
  logic [127:0] req_wdata_i = '0;
  logic         rsp_valid_o, rsp_err_o;
  logic [127:0] rsp_data_o;
  logic         cyc_o, stb_o, we_o;
  logic [31:0]  adr_o, dat_o;
  logic [3:0]   sel_o;
  logic [2:0]   cti_o;
  logic [1:0]   bte_o;
  logic [31:0]  dat_i = '0;
  logic         ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0, stall_i = 1'b0;

  always #5 clk_i = ~clk_i;

  wb_burst_master #(
    .ADDR_W(32), .DATA_W(32), .LINE_W(128), .MAX_RETRY(MAXR), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_line_i(req_line_i),
    .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_data_o(rsp_data_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .cti_o(cti_o), .bte_o(bte_o),
    .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .stall_i(stall_i)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave memory (written by bus beats) and reference memory (written by the model).
  logic [31:0]  slv_mem [int unsigned];
  logic [31:0]  ref_mem [int unsigned];
  logic [127:0] exp_buf = '0;
  logic [127:0] last_rsp_data;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic we, input logic line,
                              input logic [15:0] s, input logic [127:0] wd);
    txn_t t;
    t.addr = a; t.we = we; t.line = line; t.sel = s; t.wdata = wd;
    t.lat = 1; t.stall_pct = 0; t.stall_beat = -1;
    t.rty_n = 0; t.err_beat = -1; t.noack = 1'b0;
    return t;
  endfunction

  task automatic run_txn(input string name, input txn_t t);
    int n, w0, idx, c, k_acc, backoffs, cyc_cycles, stb_cycles, rty_left;
    int stall_run, beat_stall, acked, exp_bo;
    bit done, err_prev, rty_prev, over, clean, exp_err, stall;
    logic [31:0] base, e_adr, a;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic        got_err;
    logic [127:0] got_data;
    pend_t pend_q[$];
    pend_t p;

    n = t.line ? NB : 1;
    w0 = int'(t.addr[3:2]);
    base = t.addr - (t.addr % 16);
    rty_left = t.rty_n;
    c = 0; k_acc = 0; backoffs = 0; cyc_cycles = 0; stb_cycles = 0;
    stall_run = 0; beat_stall = 0; done = 0; err_prev = 0; rty_prev = 0;
    got_err = 1'b0; got_data = '0;

    @(negedge clk_i);
    check_val({name, "/ready"}, req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_addr_i = t.addr; req_we_i = t.we; req_line_i = t.line;
    req_sel_i = t.sel; req_wdata_i = t.wdata;

    while (!done && c < 200) begin
      @(negedge clk_i);
      c++;
      req_valid_i = 1'b0;
      stall_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; dat_i = '0;
      if (err_prev) check_val({name, "/err_drop"}, {cyc_o, rsp_valid_o}, 2'b01);
      if (rty_prev) check_val({name, "/rty_drop"}, cyc_o, 1'b0);
      err_prev = 0; rty_prev = 0;
      if (rsp_valid_o) begin
        done = 1; got_err = rsp_err_o; got_data = rsp_data_o;
      end else if (!cyc_o) begin
        backoffs++; pend_q.delete(); k_acc = 0; beat_stall = 0; stall_run = 0;
      end else begin
        cyc_cycles++;
        if (stb_o) begin
          stb_cycles++;
          check_val({name, "/beat_in_range"}, k_acc < n, 1'b1);
          idx   = t.line ? (w0 + k_acc) % NB : w0;
          e_adr = t.line ? base + 32'(idx * 4) : t.addr;
          e_sel = t.line ? 4'hF : t.sel[w0*4 +: 4];
          e_cti = !t.line ? 3'b000 : (k_acc == n - 1) ? 3'b111 : 3'b010;
          check_val({name, "/adr"}, adr_o, e_adr);
          check_val({name, "/sel"}, sel_o, e_sel);
          check_val({name, "/cti"}, cti_o, e_cti);
          check_val({name, "/bte"}, bte_o, t.line ? 2'b01 : 2'b00);
          check_val({name, "/we"}, we_o, t.we);
          if (t.we) check_val({name, "/dat"}, dat_o, t.wdata[idx*32 +: 32]);
          stall = 0;
          if (t.stall_beat == k_acc && beat_stall < 3) begin
            stall = 1; beat_stall++;
          end else if (t.stall_pct > 0 && stall_run < 2 && $urandom_range(99) < t.stall_pct) begin
            stall = 1;
          end
          stall_run = stall ? stall_run + 1 : 0;
          stall_i = stall;
          if (!stall) begin
            pend_q.push_back('{k_acc, c, adr_o, dat_o, sel_o});
            k_acc++;
          end
        end
        if (pend_q.size() > 0 && !t.noack && pend_q[0].cyc + t.lat <= c) begin
          p = pend_q.pop_front();
          a = p.adr & ~32'd3;
          if (rty_left > 0) begin
            rty_i = 1'b1; rty_left--; rty_prev = 1;
          end else if (p.k == t.err_beat) begin
            err_i = 1'b1; err_prev = 1;
          end else begin
            ack_i = 1'b1;
            if (t.we) slv_mem[a] = merge(slv_rd(a), p.dat, p.sel);
            else dat_i = slv_rd(a);
          end
        end
      end
    end
    stall_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;

    check_val({name, "/rsp_seen"}, done, 1'b1);

    // Request-level prediction.
    over    = t.rty_n > MAXR;
    exp_err = over || t.err_beat >= 0 || t.noack;
    acked   = (over || t.noack) ? 0 : (t.err_beat >= 0 ? t.err_beat : n);
    exp_bo  = over ? MAXR : t.rty_n;
    clean   = !exp_err && t.rty_n == 0;
    for (int k = 0; k < acked; k++) begin
      idx = t.line ? (w0 + k) % NB : w0;
      a = base + 32'(idx * 4);
      if (t.we) ref_mem[a] = merge(ref_rd(a), t.wdata[idx*32 +: 32], t.line ? 4'hF : t.sel[w0*4 +: 4]);
      else if (t.line) exp_buf[idx*32 +: 32] = ref_rd(a);
      else exp_buf = {4{ref_rd(a)}};
    end

    if (done) begin
      check_val({name, "/rsp_err"}, got_err, exp_err);
      check_val({name, "/rsp_data"}, got_data, exp_buf);
      check_val({name, "/backoffs"}, backoffs, exp_bo);
      if (t.noack) check_val({name, "/tmo_cycles"}, cyc_cycles, TMO);
      if (clean) check_val({name, "/beats"}, k_acc, n);
      if (clean && t.stall_pct == 0 && t.stall_beat < 0) begin
        check_val({name, "/latency"}, c, n + 1 + t.lat);
        check_val({name, "/stb_cycles"}, stb_cycles, n);
      end
      for (int j = 0; j < NB; j++)
        check_val({name, "/mem"}, slv_rd(base + 32'(j * 4)), ref_rd(base + 32'(j * 4)));
    end
    last_rsp_data = got_data;
    $display("txn %-6s addr=%08h we=%0d line=%0d lat=%0d rty=%0d errb=%0d noack=%0d -> err=%0d cycles=%0d",
             name, t.addr, t.we, t.line, t.lat, t.rty_n, t.err_beat, t.noack, got_err, c);

    @(negedge clk_i);
    check_val({name, "/pulse_one"}, rsp_valid_o, 1'b0);
    check_val({name, "/data_hold"}, rsp_data_o, exp_buf);
  endtask

  txn_t t;
  int r;
  logic [127:0] exp_line;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk_i);
    check_val("rst/ready", req_ready_o, 1'b1);
    check_val("rst/bus", {cyc_o, stb_o, we_o, cti_o, bte_o, sel_o}, '0);
    check_val("rst/adr_dat", {adr_o, dat_o}, '0);
    check_val("rst/rsp", {rsp_valid_o, rsp_err_o}, '0);
    check_val("rst/rsp_data", rsp_data_o, '0);
    rst_ni = 1'b1;

    // Critical-word line read with known data.
    slv_mem[32'h1008] = 32'hA0; ref_mem[32'h1008] = 32'hA0;
    slv_mem[32'h100C] = 32'hA1; ref_mem[32'h100C] = 32'hA1;
    slv_mem[32'h1000] = 32'hA2; ref_mem[32'h1000] = 32'hA2;
    slv_mem[32'h1004] = 32'hA3; ref_mem[32'h1004] = 32'hA3;
    run_txn("lrd", mk(32'h1008, 1'b0, 1'b1, 16'h0, '0));
    exp_line = 128'h000000A1_000000A0_000000A3_000000A2;
    check_val("lrd/literal", last_rsp_data, exp_line);

    // Line write with beat 1 stalled for three cycles.
    t = mk(32'h1040, 1'b1, 1'b1, 16'h0, 128'h44444444_33333333_22222222_11111111);
    t.stall_beat = 1;
    run_txn("lwr_st", t);

    // Single byte write.
    run_txn("sbw", mk(32'h2006, 1'b1, 1'b0, 16'h0040, 128'h0_00000000_00AB0000_0));

    // Two retries then success; four retries exhausts the limit.
    t = mk(32'h1080, 1'b0, 1'b1, 16'h0, '0); t.rty_n = 2;
    run_txn("rty2", t);
    t = mk(32'h1090, 1'b1, 1'b1, 16'h0, {4{32'hDEADBEEF}}); t.rty_n = 4;
    run_txn("rty4", t);

    // Error on beat 2 of a read.
    t = mk(32'h10A4, 1'b0, 1'b1, 16'h0, '0); t.err_beat = 2;
    run_txn("err2", t);

    // Silent slave.
    t = mk(32'h10B0, 1'b0, 1'b1, 16'h0, '0); t.noack = 1'b1;
    run_txn("tmo", t);

    // Zero-latency single read.
    t = mk(32'h10C8, 1'b0, 1'b0, 16'hFFFF, '0); t.lat = 0;
    run_txn("srd0", t);

    // Random mix.
    for (int i = 0; i < 150; i++) begin
      t = mk(32'h1000 + 32'($urandom_range(0, 255)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             16'($urandom), {$urandom, $urandom, $urandom, $urandom});
      t.lat = $urandom_range(1);
      t.stall_pct = $urandom_range(3) * 10;
      r = $urandom_range(99);
      if (r < 10) t.rty_n = $urandom_range(1, 4);
      else if (r < 16) t.err_beat = $urandom_range(t.line ? 3 : 0);
      else if (r < 19) t.noack = 1'b1;
      run_txn("rand", t);
    end

    // Reset in the middle of a stalled burst.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 32'h1100; req_we_i = 1'b0; req_line_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0; stall_i = 1'b1;
    @(negedge clk_i);
    check_val("mrst/cyc_before", cyc_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check_val("mrst/cyc", {cyc_o, stb_o}, 2'b00);
    check_val("mrst/ready", req_ready_o, 1'b1);
    check_val("mrst/rsp", rsp_valid_o, 1'b0);
    check_val("mrst/rsp_data", rsp_data_o, '0);
    @(negedge clk_i);
    stall_i = 1'b0; rst_ni = 1'b1; exp_buf = '0;
    run_txn("post", mk(32'h1104, 1'b0, 1'b1, 16'h0, '0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
